// File: rtl/score_text_buffer.sv
// Character-code grid for the on-screen text path: 16x16 x 7-bit store with a
// one-clock read port, a host write port and a self-running score renderer.
module score_text_buffer #(
    parameter int         SCORE_COL  = 8,
    parameter int         SCORE_ROW  = 0,
    parameter logic [6:0] BLANK_CHAR = 7'h20,
    parameter logic [6:0] ZERO_CHAR  = 7'h30,
    parameter bit         LZ_BLANK   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_xy,
    input  logic [3:0]  char_line,
    output logic [6:0]  char_code,
    output logic [3:0]  char_line_out,
    input  logic [15:0] score,
    input  logic        score_update,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [6:0]  wr_data,
    output logic        wr_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_CONVERT,
        S_WRITE
    } state_t;

    localparam logic [3:0] COL0 = 4'(SCORE_COL);
    localparam logic [3:0] ROW0 = 4'(SCORE_ROW);

    state_t      state, next_state;
    logic [7:0]  clr_cnt;
    logic        pending;
    logic [15:0] pend_val;
    logic [15:0] bin_sr;
    logic [19:0] bcd;
    logic [3:0]  iter;
    logic [2:0]  dig_idx;
    logic        seen_nz;

    logic [6:0]  mem [256];
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [6:0]  mem_wdata;

    logic [3:0]  cur_digit;
    logic        blank_digit;
    logic [3:0]  write_col;

    // One double-dabble iteration: +3 on every nibble >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] b, input logic in_bit);
        logic [19:0] a;
        a = b;
        for (int i = 0; i < 5; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                a[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return {a[18:0], in_bit};
    endfunction

    // The BCD register is shifted a digit per WRITE cycle, so the current digit is always the top nibble.
    assign cur_digit   = bcd[19:16];
    assign blank_digit = LZ_BLANK && !seen_nz && (cur_digit == 4'd0) && (dig_idx != 3'd4);
    assign write_col   = COL0 + 4'(dig_idx);

    assign busy     = (state != S_IDLE);
    assign wr_ready = ~busy;

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_waddr  = 8'd0;
        mem_wdata  = 7'd0;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = BLANK_CHAR;
                if (clr_cnt == 8'd255)
                    next_state = S_IDLE;
            end
            S_IDLE: begin
                if (wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = wr_data;
                end
                if (pending || score_update)
                    next_state = S_CONVERT;
            end
            S_CONVERT: begin
                if (iter == 4'd15)
                    next_state = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = {write_col, ROW0};
                mem_wdata = blank_digit ? BLANK_CHAR : (ZERO_CHAR + {3'b000, cur_digit});
                if (dig_idx == 3'd4)
                    next_state = S_IDLE;
            end
            default: next_state = S_CLEAR;
        endcase
    end

    // Control state: reset restarts the clear sweep and drops any queued redraw.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_cnt <= 8'd0;
            pending <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_CLEAR:   clr_cnt <= clr_cnt + 8'd1;
                S_IDLE:    if (pending) pending <= score_update;
                S_CONVERT,
                S_WRITE:   if (score_update) pending <= 1'b1;
                default:   ;
            endcase
        end
    end

    // Conversion datapath: pending value takes precedence over a same-cycle pulse, which is re-queued.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                iter    <= 4'd0;
                dig_idx <= 3'd0;
                seen_nz <= 1'b0;
                bcd     <= 20'd0;
                if (pending) begin
                    bin_sr <= pend_val;
                    if (score_update)
                        pend_val <= score;
                end else if (score_update) begin
                    bin_sr <= score;
                end
            end
            S_CONVERT: begin
                bcd     <= dabble_step(bcd, bin_sr[15]);
                bin_sr  <= {bin_sr[14:0], 1'b0};
                iter    <= iter + 4'd1;
                dig_idx <= 3'd0;
                if (score_update)
                    pend_val <= score;
            end
            S_WRITE: begin
                bcd     <= {bcd[15:0], 4'h0};
                dig_idx <= dig_idx + 3'd1;
                if (cur_digit != 4'd0)
                    seen_nz <= 1'b1;
                if (score_update)
                    pend_val <= score;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Read port: one clock of latency, read-first on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_code     <= 7'd0;
            char_line_out <= 4'd0;
        end else begin
            char_code     <= mem[char_xy];
            char_line_out <= char_line;
        end
    end

endmodule

// File: tb/tb_score_text_buffer.sv
// Self-checking bench for score_text_buffer: two instances (score at column 8 and 14)
// share stimulus; a grid model per instance feeds a read scoreboard.
module tb_score_text_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [15:0] score;
    logic        score_update;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [6:0]  wr_data;

    logic [6:0]  code1, code2;
    logic [3:0]  line1, line2;
    logic        rdy1, rdy2, busy1, busy2;

    always #5 clk = ~clk;

    score_text_buffer u_dut (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_line(char_line),
        .char_code(code1), .char_line_out(line1), .score(score),
        .score_update(score_update), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(rdy1), .busy(busy1)
    );

    score_text_buffer #(.SCORE_COL(14)) u_dut14 (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_line(char_line),
        .char_code(code2), .char_line_out(line2), .score(score),
        .score_update(score_update), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(rdy2), .busy(busy2)
    );

    typedef struct {
        int addr;
        int code1;
        int code2;
        int line;
    } rd_t;

    rd_t        sb[$];
    logic [6:0] model [2][256];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         p10 [5] = '{10000, 1000, 100, 10, 1};

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic compare_out();
        rd_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("code_col8@%02h", e.addr), int'(code1), e.code1);
            check($sformatf("code_col14@%02h", e.addr), int'(code2), e.code2);
            check($sformatf("line_col8@%02h", e.addr), int'(line1), e.line);
            check($sformatf("line_col14@%02h", e.addr), int'(line2), e.line);
        end
    endtask

    task automatic rd(input int a);
        rd_t e;
        @(negedge clk);
        compare_out();
        char_xy   = 8'(a);
        char_line = 4'($urandom_range(0, 15));
        e.addr  = a;
        e.code1 = int'(model[0][a]);
        e.code2 = int'(model[1][a]);
        e.line  = int'(char_line);
        sb.push_back(e);
    endtask

    task automatic rd_flush();
        @(negedge clk);
        compare_out();
    endtask

    task automatic rd_row0();
        for (int c = 0; c < 16; c++) rd(c * 16);
        rd_flush();
    endtask

    task automatic rd_all();
        for (int a = 0; a < 256; a++) rd(a);
        rd_flush();
    endtask

    task automatic pulse(input int v);
        score        = 16'(v);
        score_update = 1'b1;
        @(negedge clk);
        score_update = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) check("idle_timeout", n, 0);
    endtask

    task automatic render(input int v);
        int d, col, first_nz;
        for (int w = 0; w < 2; w++) begin
            col      = (w == 0) ? 8 : 14;
            first_nz = 0;
            for (int i = 0; i < 5; i++) begin
                d = (v / p10[i]) % 10;
                if (d != 0) first_nz = 1;
                if (first_nz == 0 && i != 4)
                    model[w][((col + i) % 16) * 16] = 7'h20;
                else
                    model[w][((col + i) % 16) * 16] = 7'(48 + d);
            end
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 256; a++) model[w][a] = 7'h20;
    endtask

    initial begin
        int n;
        int vals [3] = '{1234, 0, 65535};

        rst = 1'b1; char_xy = 8'd0; char_line = 4'h9; score = 16'd0;
        score_update = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 7'd0;
        repeat (4) @(negedge clk);
        check("rst_code", int'(code1), 0);
        check("rst_line", int'(line1), 0);
        check("rst_busy", int'(busy1), 1);
        check("rst_wr_ready", int'(rdy1), 0);
        check("rst_code14", int'(code2), 0);

        rst = 1'b0;
        wait_idle(n);
        check("clear_cycles", n, 256);
        check("idle_wr_ready", int'(rdy1), 1);
        model_clear();
        rd_all();

        for (int k = 0; k < 3; k++) begin
            pulse(vals[k]);
            wait_idle(n);
            check($sformatf("render_cycles_%0d", vals[k]), n, 21);
            render(vals[k]);
            rd_row0();
        end

        // Redraw requests during a render: latest wins, 77 is never drawn.
        pulse(5);
        repeat (2) @(negedge clk);
        pulse(77);
        pulse(99);
        wait_idle(n);
        check("first_render_cycles", n, 17);
        render(5);
        @(negedge clk);
        check("pending_restart_busy", int'(busy1), 1);
        rd_row0();
        render(99);
        wait_idle(n);
        rd_row0();

        // Host write in IDLE, with a same-cycle read of the same address.
        rd(0);
        check("wr_ready_idle", int'(rdy1), 1);
        wr_en = 1'b1; wr_addr = 8'h00; wr_data = 7'h41;
        model[0][0] = 7'h41;
        model[1][0] = 7'h41;
        rd(0);
        wr_en = 1'b0;
        rd_flush();

        // Host write while busy is dropped.
        pulse(321);
        check("wr_ready_busy", int'(rdy1), 0);
        wr_en = 1'b1; wr_addr = 8'h01; wr_data = 7'h42;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(n);
        render(321);
        rd(1);
        rd_row0();

        pulse(12345);
        wait_idle(n);
        check("render_cycles_12345", n, 21);
        render(12345);
        rd_row0();

        // Reset in the middle of WRITE re-clears everything.
        pulse(777);
        repeat (17) @(negedge clk);
        check("mid_write_busy", int'(busy1), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rerst_busy", int'(busy1), 1);
        check("rerst_code", int'(code1), 0);
        rst = 1'b0;
        wait_idle(n);
        check("reclear_cycles", n, 256);
        model_clear();
        rd_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
